// File: rtl/com_tx_send.sv
// com_tx_send: reads a staged frame (INFO + DAT_CNT data segments) back from RAM
// and streams it byte-wise, each segment closed by an 8-bit additive checksum.
module com_tx_send #(
    parameter logic [14:0] INFO_ADDR  = 15'h0100,
    parameter logic [11:0] INFO_NUM   = 12'd16,
    parameter logic [14:0] DAT_BASE   = 15'h1000,
    parameter logic [14:0] DAT_STRIDE = 15'h1200,
    parameter logic [11:0] DATA_NUM   = 12'd100,
    parameter logic [2:0]  DAT_CNT    = 3'd6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fs,
    output logic        fd,
    output logic [14:0] ram_data_rxa,
    input  logic [7:0]  ram_data_rxd,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last
);

    localparam logic [3:0] IDLE = 4'd0;
    localparam logic [3:0] WAIT = 4'd1;
    localparam logic [3:0] SEG  = 4'd2;
    localparam logic [3:0] RDLY = 4'd3;
    localparam logic [3:0] LOAD = 4'd4;
    localparam logic [3:0] SEND = 4'd5;
    localparam logic [3:0] SUML = 4'd6;
    localparam logic [3:0] SUMT = 4'd7;
    localparam logic [3:0] DONE = 4'd8;

    logic [3:0]  state_q, state_d;
    logic [14:0] rxa_q, rxa_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic [11:0] cnt_q, cnt_d;
    logic [2:0]  seg_q, seg_d;
    logic [7:0]  sum_q, sum_d;

    logic [2:0]  seg_m1;
    logic [14:0] seg_addr;
    logic [11:0] last_idx;
    logic        hs;

    // segment 0 is INFO; data segment n sits at DAT_BASE + n*DAT_STRIDE (mod 2^15)
    assign seg_m1   = seg_q - 3'd1;
    assign seg_addr = (seg_q == 3'd0) ? INFO_ADDR
                                      : DAT_BASE + 15'(seg_m1) * DAT_STRIDE;
    assign last_idx = (seg_q == 3'd0) ? INFO_NUM - 12'd1 : DATA_NUM - 12'd1;
    assign hs       = valid_q && tx_ready;

    always_comb begin
        state_d = state_q;
        rxa_d   = rxa_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        seg_d   = seg_q;
        sum_d   = sum_q;
        unique case (state_q)
            IDLE: state_d = WAIT;
            WAIT: if (fs) state_d = SEG;
            SEG: begin
                rxa_d   = seg_addr;
                cnt_d   = 12'd0;
                sum_d   = 8'd0;
                state_d = RDLY;
            end
            RDLY: state_d = LOAD;
            LOAD: begin
                data_d  = ram_data_rxd;
                sum_d   = sum_q + ram_data_rxd;
                valid_d = 1'b1;
                last_d  = 1'b0;
                state_d = SEND;
            end
            SEND: begin
                if (hs) begin
                    valid_d = 1'b0;
                    rxa_d   = rxa_q + 15'd1;
                    cnt_d   = cnt_q + 12'd1;
                    state_d = (cnt_q == last_idx) ? SUML : RDLY;
                end
            end
            SUML: begin
                data_d  = sum_q;
                valid_d = 1'b1;
                last_d  = 1'b1;
                state_d = SUMT;
            end
            SUMT: begin
                if (hs) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (seg_q == DAT_CNT) begin
                        state_d = DONE;
                    end else begin
                        seg_d   = seg_q + 3'd1;
                        state_d = SEG;
                    end
                end
            end
            DONE: begin
                if (!fs) begin
                    state_d = WAIT;
                    seg_d   = 3'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rxa_q   <= 15'd0;
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= 12'd0;
            seg_q   <= 3'd0;
            sum_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            rxa_q   <= rxa_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            seg_q   <= seg_d;
            sum_q   <= sum_d;
        end
    end

    assign fd           = (state_q == DONE);
    assign ram_data_rxa = rxa_q;
    assign tx_data      = data_q;
    assign tx_valid     = valid_q;
    assign tx_last      = last_q;

endmodule

// File: tb/tb_com_tx_send.sv
// tb_com_tx_send: random-ready frame checks against a queue-based frame model,
// plus a reduced-geometry instance for the small-segment case.
module tb_com_tx_send;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, fs1, fs2, tx_ready, sel;

    logic        fd1, tx_valid1, tx_last1;
    logic [14:0] rxa1;
    logic [7:0]  rxd1, tx_data1;
    logic        fd2, tx_valid2, tx_last2;
    logic [14:0] rxa2;
    logic [7:0]  rxd2, tx_data2;

    logic [7:0] mem1 [32768];
    logic [7:0] mem2 [32768];

    always @(posedge clk) rxd1 <= mem1[rxa1];
    always @(posedge clk) rxd2 <= mem2[rxa2];

    com_tx_send u_dut1 (
        .clk(clk), .rst(rst), .fs(fs1), .fd(fd1),
        .ram_data_rxa(rxa1), .ram_data_rxd(rxd1),
        .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready), .tx_last(tx_last1)
    );

    com_tx_send #(.DATA_NUM(12'd1), .DAT_CNT(3'd1)) u_dut2 (
        .clk(clk), .rst(rst), .fs(fs2), .fd(fd2),
        .ram_data_rxa(rxa2), .ram_data_rxd(rxd2),
        .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready), .tx_last(tx_last2)
    );

    logic [7:0]  s_data;
    logic        s_valid, s_last, s_fd;
    logic [14:0] s_rxa;
    assign s_data  = sel ? tx_data2  : tx_data1;
    assign s_valid = sel ? tx_valid2 : tx_valid1;
    assign s_last  = sel ? tx_last2  : tx_last1;
    assign s_fd    = sel ? fd2       : fd1;
    assign s_rxa   = sel ? rxa2      : rxa1;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  exp_d [$];
    bit          exp_l [$];
    logic [14:0] exp_a [$];
    logic [7:0]  got   [$];

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // frame model: segment list -> byte list with running mod-256 sum
    task automatic build_exp(input bit s, input int info_num,
                             input int data_num, input int dat_cnt);
        int base, n;
        logic [7:0] b, sum;
        logic [14:0] a;
        exp_d.delete();
        exp_l.delete();
        exp_a.delete();
        for (int g = 0; g <= dat_cnt; g++) begin
            base = (g == 0) ? 'h100 : 'h1000 + (g - 1) * 'h1200;
            n = (g == 0) ? info_num : data_num;
            sum = 8'd0;
            for (int k = 0; k < n; k++) begin
                a = 15'((base + k) % 32768);
                b = s ? mem2[a] : mem1[a];
                sum = sum + b;
                exp_d.push_back(b);
                exp_l.push_back(1'b0);
                exp_a.push_back(a);
            end
            exp_d.push_back(sum);
            exp_l.push_back(1'b1);
            exp_a.push_back(15'd0);
        end
    endtask

    task automatic run_frame(input int pct, input int abort_at);
        bit stall = 1'b0;
        bit done = 1'b0;
        logic [7:0] pd = 8'd0;
        logic pl = 1'b0;
        int idx = 0;
        got.delete();
        for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
            @(negedge clk);
            if (stall) begin
                check("hold_valid", s_valid, 1);
                check("hold_data", s_data, pd);
                check("hold_last", s_last, pl);
            end
            stall = s_valid && !tx_ready;
            pd = s_data;
            pl = s_last;
            if (s_valid && tx_ready) begin
                if (abort_at >= 0 && idx == abort_at) return;
                if (idx < exp_d.size()) begin
                    check("data", s_data, exp_d[idx]);
                    check("last", s_last, exp_l[idx]);
                    if (!exp_l[idx]) check("addr", s_rxa, exp_a[idx]);
                end else begin
                    check("extra_byte", idx, exp_d.size());
                end
                got.push_back(s_data);
                idx++;
            end
            if (s_fd) begin
                done = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                tx_ready = ($urandom_range(99) < pct);
            end
        end
        check("frame_done", done, 1);
        check("byte_count", idx, exp_d.size());
    endtask

    initial begin
        int vcnt;
        rst = 1'b1;
        fs1 = 1'b0;
        fs2 = 1'b0;
        tx_ready = 1'b0;
        sel = 1'b0;
        for (int a = 0; a < 32768; a++) begin
            mem1[a] = 8'($urandom);
            mem2[a] = 8'hFF;
        end
        for (int i = 0; i < 16; i++) mem1['h100 + i] = 8'(i);
        for (int n = 0; n < 6; n++)
            for (int k = 0; k < 100; k++) mem1['h1000 + n * 'h1200 + k] = 8'(k);

        repeat (2) @(negedge clk);
        check("rst_data", tx_data1, 0);
        check("rst_valid", tx_valid1, 0);
        check("rst_last", tx_last1, 0);
        check("rst_fd", fd1, 0);
        check("rst_rxa", rxa1, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // full-rate frame with fixed pattern
        build_exp(1'b0, 16, 100, 6);
        tx_ready = 1'b1;
        fs1 = 1'b1;
        run_frame(100, -1);
        check("info_sum", got[16], 8'h78);
        check("dat0_sum", got[117], 8'h56);
        check("dat5_sum", got[622], 8'h56);
        check("fd_set", fd1, 1);

        // fs held high: no second frame
        vcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx_valid1) vcnt++;
        end
        check("no_refire", vcnt, 0);
        check("fd_hold", fd1, 1);

        // fs low one clock then high: identical frame, throttled sink
        @(posedge clk);
        #1 fs1 = 1'b0;
        @(posedge clk);
        #1 fs1 = 1'b1;
        run_frame(30, -1);

        // random contents, reset mid DAT2 byte 40
        @(posedge clk);
        #1 fs1 = 1'b0;
        repeat (3) @(posedge clk);
        for (int a = 0; a < 32768; a++) mem1[a] = 8'($urandom);
        build_exp(1'b0, 16, 100, 6);
        #1 fs1 = 1'b1;
        run_frame(30, 259);
        rst = 1'b1;
        fs1 = 1'b0;
        #1;
        check("mid_rst_data", tx_data1, 0);
        check("mid_rst_valid", tx_valid1, 0);
        check("mid_rst_last", tx_last1, 0);
        check("mid_rst_fd", fd1, 0);
        check("mid_rst_rxa", rxa1, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 fs1 = 1'b1;
        run_frame(30, -1);

        // reduced geometry: one-byte data segment, all 0xFF
        @(posedge clk);
        #1 fs1 = 1'b0;
        sel = 1'b1;
        build_exp(1'b1, 16, 1, 1);
        tx_ready = 1'b1;
        fs2 = 1'b1;
        run_frame(100, -1);
        check("small_count", got.size(), 19);
        check("small_info_sum", got[16], 8'hF0);
        check("small_dat_sum", got[18], 8'hFF);
        check("small_fd", fd2, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
